// File: rtl/output_dispatch.sv
// Latest-value-per-channel store with round-robin dispatch onto a
// single valid/ready output; stale pending values are overwritten.
module output_dispatch #(
    parameter int W_CHAN = 5,
    parameter int N_CHAN = 8,
    parameter int W_DATA = 64
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              dv_in,
    input  logic [W_CHAN-1:0] chan_in,
    input  logic [W_DATA-1:0] data_in,
    input  logic              rdy_in,
    output logic              dv_out,
    output logic [W_CHAN-1:0] chan_out,
    output logic [W_DATA-1:0] data_out,
    output logic              ovr_out
);

    localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam logic [W_CHAN:0]   LP_NCH  = (W_CHAN+1)'(N_CHAN);
    localparam logic [W_CHAN-1:0] LP_LAST = W_CHAN'(N_CHAN - 1);

    logic [W_DATA-1:0] r_mem [N_CHAN];
    logic [N_CHAN-1:0] r_pend;
    logic [W_CHAN-1:0] r_last;
    logic              r_dv;
    logic [W_CHAN-1:0] r_chan;
    logic [W_DATA-1:0] r_data;
    logic              r_ovr;

    logic              w_cap;
    logic              w_free;
    logic              w_gnt_vld;
    logic [W_CHAN-1:0] w_gnt;
    logic              w_take;
    logic              w_ovr;
    logic [N_CHAN-1:0] w_pend_nxt;

    assign w_cap  = dv_in && ({1'b0, chan_in} < LP_NCH);
    assign w_free = !r_dv || rdy_in;
    assign w_take = w_free && w_gnt_vld;

    // Round-robin search: nearest pending channel after last grant wins
    always_comb begin
        logic [W_CHAN:0] v_sum;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        v_sum     = '0;
        for (int k = N_CHAN; k >= 1; k--) begin
            v_sum = {1'b0, r_last} + (W_CHAN+1)'(k);
            if (v_sum >= LP_NCH) begin
                v_sum = v_sum - LP_NCH;
            end
            if (r_pend[v_sum[W_IDX-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = v_sum[W_CHAN-1:0];
            end
        end
    end

    // Pending flags: grant clears, capture sets (capture wins on collision)
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovr      = 1'b0;
        if (w_take) begin
            w_pend_nxt[w_gnt[W_IDX-1:0]] = 1'b0;
        end
        if (w_cap) begin
            w_ovr = r_pend[chan_in[W_IDX-1:0]]
                    && !(w_take && (w_gnt == chan_in));
            w_pend_nxt[chan_in[W_IDX-1:0]] = 1'b1;
        end
    end

    // Data store: not reset, only ever read under a pending flag
    always_ff @(posedge clk_in) begin
        if (!rst_in && w_cap) begin
            r_mem[chan_in[W_IDX-1:0]] <= data_in;
        end
    end

    // Control state and output register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pend <= '0;
            r_last <= LP_LAST;
            r_dv   <= 1'b0;
            r_chan <= '0;
            r_data <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ovr  <= w_ovr;
            if (w_free) begin
                r_dv <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_chan <= w_gnt;
                    r_data <= r_mem[w_gnt[W_IDX-1:0]];
                    r_last <= w_gnt;
                end
            end
        end
    end

    assign dv_out   = r_dv;
    assign chan_out = r_chan;
    assign data_out = r_data;
    assign ovr_out  = r_ovr;

endmodule

// File: tb/tb_output_dispatch.sv
// Directed vector table plus randomized run against a
// behavioural model of the dispatch store.
module tb_output_dispatch;

    localparam int NC = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        dv_in = 1'b0;
    logic [4:0]  chan_in = '0;
    logic [63:0] data_in = '0;
    logic        rdy_in = 1'b0;
    logic        dv_out;
    logic [4:0]  chan_out;
    logic [63:0] data_out;
    logic        ovr_out;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    output_dispatch #(.W_CHAN(5), .N_CHAN(NC), .W_DATA(64)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .dv_in(dv_in),
        .chan_in(chan_in), .data_in(data_in), .rdy_in(rdy_in),
        .dv_out(dv_out), .chan_out(chan_out), .data_out(data_out),
        .ovr_out(ovr_out)
    );

    typedef struct {
        bit          rst;
        bit          dv;
        int          ch;
        logic [63:0] d;
        bit          rdy;
        bit          e_dv;
        bit          chk_cd;
        int          e_ch;
        logic [63:0] e_d;
        bit          e_ovr;
    } vec_t;

    vec_t tv[$];

    // behavioural model state
    bit          m_pend [NC];
    logic [63:0] m_mem [NC];
    int          m_last;
    bit          m_dv;
    int          m_ch;
    logic [63:0] m_data;
    bit          m_ovr;

    task automatic add(input bit rst, input bit dv, input int ch,
                       input logic [63:0] d, input bit rdy,
                       input bit e_dv, input bit chk_cd, input int e_ch,
                       input logic [63:0] e_d, input bit e_ovr);
        vec_t v;
        v = '{rst, dv, ch, d, rdy, e_dv, chk_cd, e_ch, e_d, e_ovr};
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_run++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic step(input bit rst, input bit dv, input int ch,
                        input logic [63:0] d, input bit rdy);
        rst_in  = rst;
        dv_in   = dv;
        chan_in = 5'(ch);
        data_in = d;
        rdy_in  = rdy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic model(input bit rst, input bit dv, input int ch,
                         input logic [63:0] d, input bit rdy);
        bit free;
        int g;
        bit cap;
        bit novr;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_dv = 0; m_ch = 0; m_data = '0; m_ovr = 0; m_last = NC - 1;
            return;
        end
        free = !m_dv || rdy;
        g = -1;
        if (free) begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_last + k) % NC;
                if (m_pend[c] && g < 0) g = c;
            end
        end
        cap = dv && (ch < NC);
        novr = cap && m_pend[ch % NC] && (g != ch);
        if (free) begin
            if (g >= 0) begin
                m_dv = 1; m_ch = g; m_data = m_mem[g];
                m_pend[g] = 0; m_last = g;
            end else begin
                m_dv = 0;
            end
        end
        if (cap) begin
            m_mem[ch] = d;
            m_pend[ch] = 1;
        end
        m_ovr = novr;
    endtask

    initial begin
        // reset
        add(1,0,0,0,1,        0,1,0,0,0);
        // single dispatch, two edges latency
        add(0,1,3,'h12345,1,  0,0,0,0,0);
        add(0,0,0,0,1,        1,1,3,'h12345,0);
        add(0,0,0,0,1,        0,0,0,0,0);
        // hold under back-pressure, then round-robin drain
        add(0,1,0,'hA0,0,     0,0,0,0,0);
        add(0,1,5,'hA5,0,     1,1,0,'hA0,0);
        add(0,1,2,'hA2,0,     1,1,0,'hA0,0);
        add(0,0,0,0,0,        1,1,0,'hA0,0);
        add(0,0,0,0,1,        1,1,2,'hA2,0);
        add(0,0,0,0,1,        1,1,5,'hA5,0);
        add(0,0,0,0,1,        0,0,0,0,0);
        // overwrite while busy -> one ovr pulse, latest value sent
        add(0,1,6,'h66,0,     0,0,0,0,0);
        add(0,1,1,10,0,       1,1,6,'h66,0);
        add(0,1,1,20,0,       1,1,6,'h66,1);
        add(0,0,0,0,0,        1,1,6,'h66,0);
        add(0,0,0,0,1,        1,1,1,20,0);
        add(0,0,0,0,1,        0,0,0,0,0);
        // ch7 refilled every cycle does not starve ch0
        add(0,1,7,'h70,0,     0,0,0,0,0);
        add(0,1,0,'hB0,0,     1,1,7,'h70,0);
        add(0,1,7,'h71,1,     1,1,0,'hB0,0);
        add(0,1,7,'h72,1,     1,1,7,'h71,0);
        add(0,1,7,'h73,1,     1,1,7,'h72,0);
        add(0,0,0,0,1,        1,1,7,'h73,0);
        add(0,0,0,0,1,        0,0,0,0,0);
        // grant/capture collision on ch4
        add(0,1,4,'hAA,0,     0,0,0,0,0);
        add(0,1,4,'hBB,0,     1,1,4,'hAA,0);
        add(0,0,0,0,1,        1,1,4,'hBB,0);
        add(0,0,0,0,1,        0,0,0,0,0);
        // out-of-range channel ignored
        add(0,1,9,'h99,1,     0,0,0,0,0);
        add(0,0,0,0,1,        0,0,0,0,0);
        // reset mid-transfer with capture in the reset cycle
        add(0,1,2,'hC2,0,     0,0,0,0,0);
        add(0,0,0,0,0,        1,1,2,'hC2,0);
        add(0,1,3,'hC3,0,     1,1,2,'hC2,0);
        add(1,1,5,'hC5,0,     0,1,0,0,0);
        add(0,0,0,0,1,        0,0,0,0,0);
        add(0,0,0,0,1,        0,0,0,0,0);

        #1;
        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].dv, tv[i].ch, tv[i].d, tv[i].rdy);
            chk($sformatf("vec%0d dv_out", i), 64'(dv_out), 64'(tv[i].e_dv));
            chk($sformatf("vec%0d ovr_out", i), 64'(ovr_out),
                64'(tv[i].e_ovr));
            if (tv[i].chk_cd) begin
                chk($sformatf("vec%0d chan_out", i), 64'(chan_out),
                    64'(tv[i].e_ch));
                chk($sformatf("vec%0d data_out", i), data_out, tv[i].e_d);
            end
        end

        // randomized run against the model
        model(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit          r;
            bit          dv;
            int          ch;
            logic [63:0] d;
            bit          rdy;
            r   = ($urandom_range(0, 299) == 0);
            dv  = ($urandom_range(0, 9) < 6);
            ch  = $urandom_range(0, 9);
            d   = {$urandom, $urandom};
            rdy = (n % 400 < 200) ? ($urandom_range(0, 9) < 8)
                                  : ($urandom_range(0, 9) < 3);
            model(r, dv, ch, d, rdy);
            step(r, dv, ch, d, rdy);
            chk($sformatf("rnd%0d dv_out", n), 64'(dv_out), 64'(m_dv));
            chk($sformatf("rnd%0d ovr_out", n), 64'(ovr_out), 64'(m_ovr));
            if (m_dv) begin
                chk($sformatf("rnd%0d chan_out", n), 64'(chan_out),
                    64'(m_ch));
                chk($sformatf("rnd%0d data_out", n), data_out, m_data);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
